hdmi_linebuf_ctrl: RTL and testbench

//  Ping-pong controller for the 1024x24 hdmi_linebuffer simple dual-port RAM, run in one clock domain.

---
 rtl/hdmi_linebuf_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hdmi_linebuf_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_linebuf_ctrl.sv
// rtl/hdmi_linebuf_ctrl.sv - ping-pong line buffer controller for a 1-cycle-latency simple dual-port RAM
module hdmi_linebuf_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 10,
  parameter int LINE_MAX   = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_eol,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_eol,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [1:0]            bank_full,
  output logic                  trunc_err
);

  localparam int OW = ADDR_WIDTH - 1;
  localparam int CW = ADDR_WIDTH;
  localparam logic [CW-1:0] LAST_OFF = CW'(LINE_MAX - 1);

  typedef enum logic [1:0] {IDLE, READ, LAST} state_t;
  state_t state, state_nx;

  logic                  wr_bank;
  logic                  rd_bank;
  logic [1:0]            full;
  logic [1:0]            full_nx;
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         len [2];
  logic                  drop;
  logic                  trunc;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  inflight;
  logic                  inflight_eol;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_eol;
  logic                  fifo_wp;
  logic                  fifo_rp;
  logic [1:0]            fifo_occ;

  logic                  accept;
  logic                  line_end;
  logic                  pop;
  logic                  capture_last;
  logic [2:0]            credit;
  logic                  issue;
  logic                  issue_last;

  // Drop mode keeps s_ready high so the tail of an overlong line is swallowed.
  assign s_ready      = !rst && (drop || !full[wr_bank]);
  assign accept       = s_valid && s_ready;
  assign line_end     = accept && !drop && (s_eol || wr_cnt == LAST_OFF);
  assign m_valid      = !rst && (fifo_occ != 2'd0);
  assign pop          = m_valid && m_ready;
  assign capture_last = inflight && inflight_eol;
  assign credit       = {1'b0, fifo_occ} + {2'b00, inflight} - {2'b00, pop};

  assign m_data      = fifo_data[fifo_rp];
  assign m_eol       = m_valid && fifo_eol[fifo_rp];
  assign ram_wr_en   = wr_en_q && !rst;
  assign ram_wr_addr = rst ? '0 : wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_addr = rst ? '0 : {rd_bank, rd_cnt[OW-1:0]};
  assign bank_full   = full;
  assign trunc_err   = trunc && !rst;

  always_comb begin
    full_nx = full;
    if (capture_last) full_nx[rd_bank] = 1'b0;
    if (line_end)     full_nx[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: if (full[rd_bank]) state_nx = READ;
      READ: begin
        // Never let FIFO entries plus the read in flight exceed its two slots.
        if (credit < 3'd2) begin
          issue = 1'b1;
          if (rd_cnt == len[rd_bank] - CW'(1)) begin
            issue_last = 1'b1;
            state_nx   = LAST;
          end
        end
      end
      LAST: if (capture_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      len[0]    <= '0;
      len[1]    <= '0;
      drop      <= 1'b0;
      trunc     <= 1'b0;
      full      <= 2'b00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      full    <= full_nx;
      wr_en_q <= accept && !drop;
      if (accept && !drop) begin
        wr_addr_q <= {wr_bank, wr_cnt[OW-1:0]};
        wr_data_q <= s_data;
      end
      if (accept) begin
        if (drop) begin
          if (s_eol) drop <= 1'b0;
        end else if (line_end) begin
          len[wr_bank] <= wr_cnt + CW'(1);
          wr_bank      <= !wr_bank;
          wr_cnt       <= '0;
          if (!s_eol) begin
            trunc <= 1'b1;
            drop  <= 1'b1;
          end
        end else begin
          wr_cnt <= wr_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank      <= 1'b0;
      rd_cnt       <= '0;
      inflight     <= 1'b0;
      inflight_eol <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_eol     <= 2'b00;
      fifo_wp      <= 1'b0;
      fifo_rp      <= 1'b0;
      fifo_occ     <= 2'd0;
    end else begin
      inflight     <= issue;
      inflight_eol <= issue_last;
      if (state == IDLE)  rd_cnt <= '0;
      else if (issue)     rd_cnt <= rd_cnt + CW'(1);
      if (capture_last)   rd_bank <= !rd_bank;
      if (inflight) begin
        fifo_data[fifo_wp] <= ram_rd_data;
        fifo_eol[fifo_wp]  <= inflight_eol;
        fifo_wp            <= !fifo_wp;
      end
      if (pop) fifo_rp <= !fifo_rp;
      fifo_occ <= fifo_occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_hdmi_linebuf_ctrl.sv
// tb/tb_hdmi_linebuf_ctrl.sv - directed self-checking bench for hdmi_linebuf_ctrl with a behavioural RAM
module tb_hdmi_linebuf_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        s_eol = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic        m_eol;
  logic        ram_wr_en;
  logic [9:0]  ram_wr_addr;
  logic [23:0] ram_wr_data;
  logic [9:0]  ram_rd_addr;
  logic [23:0] ram_rd_data;
  logic [1:0]  bank_full;
  logic        trunc_err;

  hdmi_linebuf_ctrl #(.DATA_WIDTH(24), .ADDR_WIDTH(10), .LINE_MAX(512)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_eol(s_eol),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_eol(m_eol),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .bank_full(bank_full), .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  logic [23:0] ram [1024];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram[ram_rd_addr];
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          to_cnt = 0;
  int          stall_viol = 0;
  int          stall_seen = 0;
  logic        stall_prev = 1'b0;
  logic [23:0] held = '0;
  logic [24:0] q [$];
  int          qc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stall_prev && m_valid && m_data !== held) stall_viol++;
    stall_prev = !rst && m_valid && !m_ready;
    if (stall_prev) stall_seen++;
    held = m_data;
    if (!rst && m_valid && m_ready) begin
      q.push_back({m_eol, m_data});
      qc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [23:0] d, input logic e);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_eol   = e;
    while (!s_ready && w < 2000) begin
      tick();
      w++;
    end
    if (w >= 2000) to_cnt++;
    tick();
  endtask

  task automatic send_line(input logic [23:0] base, input int n);
    for (int i = 0; i < n; i++) send_beat(base + 24'(i), i == n - 1);
    s_valid = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    int w = 0;
    while (q.size() < n && w < 3000) begin
      tick();
      w++;
    end
    repeat (6) tick();
    chk(tag, q.size(), n);
  endtask

  task automatic chk_line(input string tag, input int start, input logic [23:0] base, input int n);
    int bad = 0;
    logic [24:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = {(i == n - 1), base + 24'(i)};
      if (start + i >= q.size()) bad++;
      else if (q[start + i] !== exp) bad++;
    end
    chk(tag, bad, 0);
  endtask

  int pat [6] = '{1, 0, 0, 1, 0, 1};

  initial begin
    // T1: reset held with s_valid asserted
    s_valid = 1'b1;
    s_data  = 24'hABCDEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_s_ready_rst", s_ready, 0);
      chk("t1_m_valid_rst", m_valid, 0);
      chk("t1_wr_en_rst", ram_wr_en, 0);
    end
    chk("t1_bank_full_rst", bank_full, 2'b00);
    chk("t1_trunc_rst", trunc_err, 0);
    s_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("t1_s_ready_release", s_ready, 1);

    // T2: four-pixel line, latency and back-to-back output
    m_ready = 1'b1;
    q.delete(); qc.delete();
    send_beat(24'h000001, 1'b0);
    chk("t2_wr_en", ram_wr_en, 1);
    chk("t2_wr_addr", ram_wr_addr, 10'd0);
    chk("t2_wr_data", ram_wr_data, 24'h000001);
    send_beat(24'h000002, 1'b0);
    send_beat(24'h000003, 1'b0);
    send_beat(24'h000004, 1'b1);
    s_valid = 1'b0; s_eol = 1'b0;
    chk("t2_bank_full_set", bank_full, 2'b01);
    chk("t2_m_valid_e0", m_valid, 0);
    tick();
    chk("t2_m_valid_e1", m_valid, 0);
    tick();
    chk("t2_m_valid_e2", m_valid, 0);
    tick();
    chk("t2_m_valid_e3", m_valid, 1);
    chk("t2_m_data_e3", m_data, 24'h000001);
    wait_out("t2_count", 4);
    chk_line("t2_line", 0, 24'h000001, 4);
    if (qc.size() >= 4) chk("t2_consecutive", qc[3] - qc[0], 3);
    chk("t2_bank_full_clear", bank_full, 2'b00);
    chk("t2_accept", to_cnt, 0);

    // T3: three lines with the output stalled until both banks are full
    m_ready = 1'b0;
    q.delete(); qc.delete();
    send_line(24'h000100, 8);
    send_line(24'h000200, 8);
    chk("t3_s_ready_full", s_ready, 0);
    chk("t3_bank_full_11", bank_full, 2'b11);
    repeat (4) tick();
    chk("t3_nothing_out", q.size(), 0);
    m_ready = 1'b1;
    send_line(24'h000300, 8);
    wait_out("t3_count", 24);
    chk_line("t3_line1", 0, 24'h000100, 8);
    chk_line("t3_line2", 8, 24'h000200, 8);
    chk_line("t3_line3", 16, 24'h000300, 8);
    chk("t3_accept", to_cnt, 0);

    // T4: 20-pixel line drained with an irregular m_ready pattern
    m_ready = 1'b0;
    q.delete(); qc.delete();
    stall_viol = 0;
    stall_seen = 0;
    send_line(24'h000400, 20);
    begin
      int w = 0;
      while (q.size() < 20 && w < 400) begin
        m_ready = pat[w % 6][0];
        tick();
        w++;
      end
    end
    m_ready = 1'b1;
    repeat (6) tick();
    chk("t4_count", q.size(), 20);
    chk_line("t4_line", 0, 24'h000400, 20);
    chk("t4_stall_hold", stall_viol, 0);
    chk("t4_stall_seen", stall_seen > 0, 1);

    // T5a: exactly LINE_MAX pixels ending with eol is a normal line
    q.delete(); qc.delete();
    send_line(24'h090000, 512);
    wait_out("t5a_count", 512);
    chk_line("t5a_line", 0, 24'h090000, 512);
    chk("t5a_no_trunc", trunc_err, 0);

    // T5: overlength line truncated, then a short line
    q.delete(); qc.delete();
    send_line(24'h500000, 600);
    chk("t5_trunc", trunc_err, 1);
    send_line(24'h600000, 3);
    wait_out("t5_count", 515);
    chk_line("t5_long", 0, 24'h500000, 512);
    chk_line("t5_short", 512, 24'h600000, 3);
    chk("t5_trunc_sticky", trunc_err, 1);
    chk("t5_accept", to_cnt, 0);

    // T6: reset in the middle of a line with a full bank pending
    m_ready = 1'b0;
    q.delete(); qc.delete();
    send_line(24'h000700, 4);
    for (int i = 0; i < 5; i++) send_beat(24'h000710 + 24'(i), 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_s_ready_rst", s_ready, 0);
    chk("t6_m_valid_rst", m_valid, 0);
    rst = 1'b0;
    tick();
    m_ready = 1'b1;
    repeat (30) tick();
    chk("t6_nothing_out", q.size(), 0);
    chk("t6_bank_full", bank_full, 2'b00);
    chk("t6_trunc_cleared", trunc_err, 0);
    send_line(24'h000800, 3);
    wait_out("t6_count", 3);
    chk_line("t6_line", 0, 24'h000800, 3);
    chk("t6_accept", to_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
